// File: rtl/sw_seq_lock_pkg.sv
// Shared types and helpers for the switch-sequence lock.
package sw_seq_lock_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone, StLock} state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sw_seq_lock_if.sv
// Switch/code inputs and step/status outputs of the switch-sequence lock.
interface sw_seq_lock_if #(
  parameter int unsigned SW_W  = 3,
  parameter int unsigned STEPS = 6
);
  localparam int unsigned STEP_W = $clog2(STEPS + 1);

  logic [SW_W-1:0]       sw;
  logic [STEPS*SW_W-1:0] code;
  logic                  clr;
  logic [STEP_W-1:0]     led;
  logic                  done;
  logic                  err;
  logic                  tout;
  logic                  locked;

  modport master (
    output sw, code, clr,
    input  led, done, err, tout, locked
  );

  modport slave (
    input  sw, code, clr,
    output led, done, err, tout, locked
  );
endinterface

// File: rtl/sw_seq_lock_timer.sv
// Up-counter shared by the RUN inactivity timeout and the LOCK duration.
module sw_seq_lock_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/sw_seq_lock.sv
// Switch-sequence lock: steps through a programmable code on sw with an inactivity
// timeout, wrong-entry counting and a timed lockout.
module sw_seq_lock
  import sw_seq_lock_pkg::*;
#(
  parameter int unsigned SW_W     = 3,
  parameter int unsigned STEPS    = 6,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned MAX_ERR  = 3,
  parameter int unsigned LOCK_CYC = 5000
) (
  input logic          clk,
  input logic          reset_n,
  sw_seq_lock_if.slave bus
);

  localparam int unsigned STEP_W = $clog2(STEPS + 1);
  localparam int unsigned CNT_W  = $clog2(max_u(TIMEOUT, LOCK_CYC) + 1);
  localparam int unsigned ERR_W  = $clog2(MAX_ERR + 1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [SW_W-1:0]   sw_q;
  logic [SW_W-1:0]   cur_code;
  logic [CNT_W-1:0]  timer_cnt;
  logic              timer_clr, timer_en;
  logic              chg, miss, expire;
  logic              done_q, err_q, tout_q, locked_q;
  logic              done_d, err_d, tout_d, locked_d;

  assign chg      = (bus.sw != sw_q);
  assign cur_code = bus.code[int'(step_q) * SW_W +: SW_W];
  assign timer_en = (state_q == StRun) || (state_q == StLock);

  sw_seq_lock_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .cnt     (timer_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      step_q    <= '0;
      err_cnt_q <= '0;
      sw_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tout_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      err_cnt_q <= err_cnt_d;
      sw_q      <= bus.sw;
      done_q    <= done_d;
      err_q     <= err_d;
      tout_q    <= tout_d;
      locked_q  <= locked_d;
    end
  end

  // The timer is cleared unless it is counting uninterrupted progress-free RUN or LOCK time.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    err_cnt_d = err_cnt_q;
    miss      = 1'b0;
    expire    = 1'b0;
    timer_clr = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (chg && (bus.sw == cur_code)) begin
          if (STEPS == 1) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            step_d  = STEP_W'(1);
          end
        end
      end
      StRun: begin
        timer_clr = 1'b0;
        if (chg && (bus.sw == cur_code)) begin
          timer_clr = 1'b1;
          if (step_q == STEP_W'(STEPS - 1)) begin
            state_d = StDone;
            step_d  = '0;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end else if (chg) begin
          miss      = 1'b1;
          timer_clr = 1'b1;
          step_d    = '0;
          if (err_cnt_q != ERR_W'(MAX_ERR)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
          state_d = (err_cnt_q == ERR_W'(MAX_ERR - 1)) ? StLock : StIdle;
        end else if (timer_cnt == CNT_W'(TIMEOUT - 1)) begin
          expire    = 1'b1;
          timer_clr = 1'b1;
          step_d    = '0;
          state_d   = StIdle;
        end
      end
      StDone: begin
        state_d   = StIdle;
        err_cnt_d = '0;
      end
      StLock: begin
        timer_clr = 1'b0;
        if (timer_cnt == CNT_W'(LOCK_CYC - 1)) begin
          timer_clr = 1'b1;
          state_d   = StIdle;
          err_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.clr && (state_q != StLock)) begin
      state_d   = StIdle;
      step_d    = '0;
      err_cnt_d = '0;
      timer_clr = 1'b1;
      miss      = 1'b0;
      expire    = 1'b0;
    end
  end

  always_comb begin
    done_d   = (state_d == StDone);
    err_d    = miss;
    tout_d   = expire;
    locked_d = (state_d == StLock);
  end

  assign bus.led    = step_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.tout   = tout_q;
  assign bus.locked = locked_q;

endmodule

// File: tb/tb_sw_seq_lock.sv
// Randomised and directed bench for sw_seq_lock against a behavioural lock model.
module tb_sw_seq_lock;

  localparam int unsigned SW_W     = 3;
  localparam int unsigned STEPS    = 6;
  localparam int unsigned TIMEOUT  = 20;
  localparam int unsigned MAX_ERR  = 3;
  localparam int unsigned LOCK_CYC = 50;
  localparam int unsigned STEP_W   = $clog2(STEPS + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sw_seq_lock_if #(.SW_W(SW_W), .STEPS(STEPS)) bus ();

  sw_seq_lock #(
    .SW_W     (SW_W),
    .STEPS    (STEPS),
    .TIMEOUT  (TIMEOUT),
    .MAX_ERR  (MAX_ERR),
    .LOCK_CYC (LOCK_CYC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int codes[STEPS] = '{1, 2, 3, 4, 5, 6};

  // Model: mode 0 idle, 1 run, 2 done, 3 lock.
  int       m_mode, m_step, m_errs, m_idle, m_lock_left;
  logic [2:0] m_swq;
  bit       e_done, e_err, e_tout;

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_errs = 0; m_idle = 0; m_lock_left = 0;
    m_swq = 3'd0; e_done = 0; e_err = 0; e_tout = 0;
  endtask

  task automatic model_edge(input logic [2:0] s, input logic c);
    bit entry;
    entry = (s != m_swq);
    e_done = 0; e_err = 0; e_tout = 0;
    if (m_mode == 3) begin
      m_lock_left--;
      if (m_lock_left == 0) begin m_mode = 0; m_errs = 0; end
    end else if (c) begin
      m_mode = 0; m_step = 0; m_errs = 0;
    end else if (m_mode == 2) begin
      m_mode = 0; m_errs = 0;
    end else if (m_mode == 0) begin
      if (entry && s == codes[0]) begin m_mode = 1; m_step = 1; m_idle = 0; end
    end else begin
      m_idle++;
      if (entry && s == codes[m_step]) begin
        m_step++; m_idle = 0;
        if (m_step == STEPS) begin m_step = 0; m_mode = 2; e_done = 1; end
      end else if (entry) begin
        e_err = 1; m_step = 0; m_errs++;
        if (m_errs == MAX_ERR) begin m_mode = 3; m_lock_left = LOCK_CYC; end
        else m_mode = 0;
      end else if (m_idle == TIMEOUT) begin
        e_tout = 1; m_step = 0; m_mode = 0;
      end
    end
    m_swq = s;
  endtask

  function automatic logic [STEP_W+3:0] exp_v();
    return {STEP_W'(m_step), e_done, e_err, e_tout, (m_mode == 3)};
  endfunction

  function automatic logic [STEP_W+3:0] obs_v();
    return {bus.led, bus.done, bus.err, bus.tout, bus.locked};
  endfunction

  task automatic tick(input logic [2:0] s, input logic c);
    bus.sw = s; bus.clr = c;
    @(posedge clk);
    model_edge(s, c);
    #1;
  endtask

  task automatic test_reset();
    bus.sw = 3'd0; bus.clr = 1'b0; reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (obs_v() !== '0) begin
      n_fail++; $display("FAIL reset outputs got %h want 0", obs_v());
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_full_seq();
    int n_done = 0;
    for (int k = 0; k < STEPS; k++) begin
      for (int h = 0; h < 3; h++) begin
        tick(3'(k + 1), 1'b0);
        n_tests++;
        if (obs_v() !== exp_v()) begin
          n_fail++; $display("FAIL full_seq k%0d h%0d got %h want %h", k, h, obs_v(), exp_v());
        end
        if (bus.done) n_done++;
      end
    end
    n_tests++;
    if (n_done != 1) begin
      n_fail++; $display("FAIL full_seq done count got %0d want 1", n_done);
    end
  endtask

  task automatic test_lockout();
    logic [2:0] pat[4] = '{3'd0, 3'd1, 3'd2, 3'd7};
    int n_err = 0, n_locked = 0, n_done = 0, guard = 0;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 4; p++) begin
        for (int h = 0; h < 2; h++) begin
          tick(pat[p], 1'b0);
          n_tests++;
          if (obs_v() !== exp_v()) begin
            n_fail++; $display("FAIL lockout r%0d p%0d got %h want %h", r, p, obs_v(), exp_v());
          end
          if (bus.err) n_err++;
          if (bus.locked) n_locked++;
        end
      end
    end
    n_tests++;
    if (n_err != 3) begin
      n_fail++; $display("FAIL lockout err count got %0d want 3", n_err);
    end
    while (m_mode == 3 && guard < 100) begin
      tick(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      guard++;
      n_tests++;
      if (obs_v() !== exp_v()) begin
        n_fail++; $display("FAIL lockout hold %0d got %h want %h", guard, obs_v(), exp_v());
      end
      if (bus.locked) n_locked++;
    end
    n_tests++;
    if (n_locked != LOCK_CYC) begin
      n_fail++; $display("FAIL lockout locked cycles got %0d want %0d", n_locked, LOCK_CYC);
    end
    tick(3'd0, 1'b0);
    for (int k = 0; k < STEPS; k++) begin
      tick(3'(k + 1), 1'b0);
      if (bus.done) n_done++;
    end
    tick(3'd6, 1'b0);
    n_tests++;
    if (n_done != 1 || bus.locked !== 1'b0) begin
      n_fail++; $display("FAIL lockout post done got %0d locked %b want 1 0", n_done, bus.locked);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] pre[5] = '{3'd1, 3'd7, 3'd1, 3'd7, 3'd1};
    int at = 0;
    for (int p = 0; p < 5; p++) tick(pre[p], 1'b0);
    for (int c = 1; c <= 30 && at == 0; c++) begin
      tick(3'd1, 1'b0);
      n_tests++;
      if (obs_v() !== exp_v()) begin
        n_fail++; $display("FAIL timeout cyc %0d got %h want %h", c, obs_v(), exp_v());
      end
      if (bus.tout) at = c;
    end
    n_tests++;
    if (at != TIMEOUT || bus.led !== '0) begin
      n_fail++; $display("FAIL timeout fired at %0d led %0d want %0d 0", at, bus.led, TIMEOUT);
    end
    // Error count kept through the timeout: one more miss locks.
    tick(3'd0, 1'b0); tick(3'd1, 1'b0); tick(3'd7, 1'b0);
    n_tests++;
    if (bus.locked !== 1'b1 || bus.err !== 1'b1) begin
      n_fail++; $display("FAIL timeout errcnt locked %b err %b want 1 1", bus.locked, bus.err);
    end
    for (int g = 0; g < 100 && m_mode == 3; g++) tick(3'd0, 1'b0);
  endtask

  task automatic test_race_clr();
    tick(3'd1, 1'b0);
    for (int c = 1; c < TIMEOUT; c++) tick(3'd1, 1'b0);
    tick(3'd2, 1'b0);
    n_tests++;
    if (bus.led !== STEP_W'(2) || bus.tout !== 1'b0 || obs_v() !== exp_v()) begin
      n_fail++; $display("FAIL race got %h want led 2 no tout (%h)", obs_v(), exp_v());
    end
    tick(3'd3, 1'b0);
    tick(3'd4, 1'b1);
    n_tests++;
    if (obs_v() !== '0 || obs_v() !== exp_v()) begin
      n_fail++; $display("FAIL clr_mid_run got %h want 0", obs_v());
    end
    tick(3'd4, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [2:0] pat[6] = '{3'd1, 3'd7, 3'd1, 3'd7, 3'd1, 3'd7};
    for (int p = 0; p < 6; p++) tick(pat[p], 1'b0);
    repeat (5) tick(3'd7, 1'b0);
    n_tests++;
    if (bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL async_reset setup locked got %b want 1", bus.locked);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (obs_v() !== '0) begin
      n_fail++; $display("FAIL async_reset outputs got %h want 0", obs_v());
    end
    @(posedge clk); @(negedge clk); reset_n = 1'b1;
    tick(3'd1, 1'b0);
    n_tests++;
    if (obs_v() !== exp_v() || bus.led !== STEP_W'(1)) begin
      n_fail++; $display("FAIL async_reset resume got %h want %h", obs_v(), exp_v());
    end
    tick(3'd1, 1'b1);
  endtask

  task automatic test_idle_errcnt();
    logic [2:0] noise[3] = '{3'd5, 3'd0, 3'd0};
    logic [2:0] two[4] = '{3'd1, 3'd7, 3'd1, 3'd7};
    for (int p = 0; p < 3; p++) begin
      tick(noise[p], 1'b0);
      n_tests++;
      if (obs_v() !== '0 || obs_v() !== exp_v()) begin
        n_fail++; $display("FAIL idle_noise p%0d got %h want 0", p, obs_v());
      end
    end
    for (int p = 0; p < 4; p++) tick(two[p], 1'b0);
    for (int k = 0; k < STEPS; k++) tick(3'(k + 1), 1'b0);
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++; $display("FAIL errcnt_done done got %b want 1", bus.done);
    end
    tick(3'd6, 1'b0);
    for (int p = 0; p < 4; p++) tick(two[p], 1'b0);
    n_tests++;
    if (bus.locked !== 1'b0 || bus.err !== 1'b1) begin
      n_fail++; $display("FAIL errcnt_cleared locked %b err %b want 0 1", bus.locked, bus.err);
    end
    tick(3'd1, 1'b0); tick(3'd7, 1'b0);
    n_tests++;
    if (bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL errcnt_third locked got %b want 1", bus.locked);
    end
  endtask

  task automatic test_random();
    int r;
    logic [2:0] s;
    logic c;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      s = bus.sw;
      c = ($urandom_range(0, 59) == 0);
      if (r < 25) s = (m_mode == 1) ? 3'(codes[m_step]) : 3'(codes[0]);
      else if (r < 35) s = 3'($urandom_range(0, 7));
      tick(s, c);
      n_tests++;
      if (obs_v() !== exp_v()) begin
        n_fail++; $display("FAIL random i%0d got %h want %h", i, obs_v(), exp_v());
      end
    end
  endtask

  initial begin
    bus.code = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    bus.sw = 3'd0;
    bus.clr = 1'b0;
    test_reset();
    test_full_seq();
    test_lockout();
    test_timeout();
    test_race_clr();
    test_async_reset();
    test_idle_errcnt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
